// File: rtl/bidir_sw_pkg.sv
// rtl/bidir_sw_pkg.sv - shared types, constants and delay clamp for the bidirectional delay switch
//
// Purpose: state encoding, direction constants and the programmable-delay
// clamp used by bidir_delay_switch and its delay line.
// Ports: none (package).

package bidir_sw_pkg;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_FWD_AC,
    ST_FWD_CA,
    ST_DRAIN,
    ST_TURN
  } sw_state_t;

  localparam logic DIR_AC = 1'b0;
  localparam logic DIR_CA = 1'b1;

  // A delay of 0 behaves as 1; anything beyond the line depth saturates.
  function automatic int clamp_dly(input int d, input int max_dly);
    if (d < 1) begin
      return 1;
    end else if (d > max_dly) begin
      return max_dly;
    end else begin
      return d;
    end
  endfunction

endpackage

// File: rtl/sw_delay_line.sv
// rtl/sw_delay_line.sv - shift register of {valid, data} stages with a selectable tap
//
// Purpose: fixed-depth delay line shared by both switch directions.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               clear valid of every stage past the input stage
//   in_valid, in_data   sample entering stage 0 on every rising edge
//   tap                 stage index presented on tap_valid/tap_data
//   tap_valid, tap_data selected stage contents
//   any_valid           some stage at or below the tap still holds a sample

module sw_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int TW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic [TW-1:0]    tap,
  output logic             tap_valid,
  output logic [WIDTH-1:0] tap_data,
  output logic             any_valid
);

  logic [DEPTH-1:0] valid_q;
  logic [WIDTH-1:0] data_q [DEPTH];

  // Stage 0 always takes the input, so a flush on the same edge as a new
  // sample still admits that sample while discarding everything older.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= in_valid;
      data_q[0]  <= in_data;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= flush ? 1'b0 : valid_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  assign tap_valid = valid_q[tap];
  assign tap_data  = data_q[tap];

  // Stages beyond the tap never reach an output, so they do not hold off drain.
  always_comb begin
    any_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (i <= int'(tap))) begin
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bidir_delay_switch.sv
// rtl/bidir_delay_switch.sv - clocked bidirectional switch with programmable delay and turnaround
//
// Purpose: connects ports A and C through one shared delay line, with
// run-time direction, drain/turnaround sequencing and contention detection.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   en, dir, dly      enable, requested direction (0 A->C, 1 C->A), delay
//   a_i/a_o/a_oe      A-side pad input, drive value, drive enable
//   c_i/c_o/c_oe      C-side pad input, drive value, drive enable
//   busy              high while draining or turning around
//   contention        sticky flag: driven pad reads back a different value

module bidir_delay_switch
  import bidir_sw_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX_DLY  = 16,
  parameter int TURN_GAP = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic                         dir,
  input  logic [$clog2(MAX_DLY+1)-1:0] dly,
  input  logic [WIDTH-1:0]             a_i,
  output logic [WIDTH-1:0]             a_o,
  output logic                         a_oe,
  input  logic [WIDTH-1:0]             c_i,
  output logic [WIDTH-1:0]             c_o,
  output logic                         c_oe,
  output logic                         busy,
  output logic                         contention
);

  localparam int DW = $clog2(MAX_DLY + 1);
  localparam int TW = (MAX_DLY > 1) ? $clog2(MAX_DLY) : 1;
  localparam int CW = (TURN_GAP > 1) ? $clog2(TURN_GAP) : 1;

  sw_state_t        state;
  logic             dir_q;
  logic [DW-1:0]    dly_q;
  logic [CW-1:0]    turn_cnt;

  logic             exit_req;
  logic             turn_done;
  logic             accept;
  logic             flush;
  logic             sel_dir;
  logic [WIDTH-1:0] src;
  logic [TW-1:0]    tap;
  logic             tap_valid;
  logic [WIDTH-1:0] tap_data;
  logic             any_valid;
  logic             route_a;
  logic             route_c;
  logic             cont_now;
  logic [DW-1:0]    dly_eff;
  sw_state_t        fwd_of_dir;

  assign exit_req   = !en || (dir != dir_q);
  assign turn_done  = (turn_cnt == '0);
  assign tap        = TW'(dly_q - DW'(1));
  assign dly_eff    = DW'(clamp_dly(32'(dly), MAX_DLY));
  assign fwd_of_dir = (dir == DIR_AC) ? ST_FWD_AC : ST_FWD_CA;

  // Outputs keep following the tap through DRAIN in the old direction.
  assign route_c = (state == ST_FWD_AC) || ((state == ST_DRAIN) && (dir_q == DIR_AC));
  assign route_a = (state == ST_FWD_CA) || ((state == ST_DRAIN) && (dir_q == DIR_CA));

  // Only a pad that has been driven for a full cycle is checked for readback.
  assign cont_now = (a_oe && (a_i != a_o)) || (c_oe && (c_i != c_o));

  // The edge that leaves OFF/TURN already captures the first sample of the new
  // direction, which makes the first oe rise exactly dly_eff edges later.
  always_comb begin
    sel_dir = dir_q;
    accept  = 1'b0;
    flush   = 1'b0;
    case (state)
      ST_OFF: begin
        flush   = 1'b1;
        sel_dir = dir;
        accept  = en;
      end
      ST_FWD_AC, ST_FWD_CA: begin
        accept = !exit_req;
      end
      ST_TURN: begin
        flush   = 1'b1;
        sel_dir = dir;
        accept  = en && turn_done;
      end
      default: begin
        accept = 1'b0;
      end
    endcase
    src = (sel_dir == DIR_AC) ? a_i : c_i;
  end

  sw_delay_line #(
    .WIDTH (WIDTH),
    .DEPTH (MAX_DLY),
    .TW    (TW)
  ) u_line (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (accept),
    .in_data   (src),
    .tap       (tap),
    .tap_valid (tap_valid),
    .tap_data  (tap_data),
    .any_valid (any_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_OFF;
      dir_q      <= DIR_AC;
      dly_q      <= DW'(1);
      turn_cnt   <= '0;
      a_o        <= '0;
      a_oe       <= 1'b0;
      c_o        <= '0;
      c_oe       <= 1'b0;
      busy       <= 1'b0;
      contention <= 1'b0;
    end else begin
      a_oe       <= route_a && tap_valid;
      a_o        <= (route_a && tap_valid) ? tap_data : '0;
      c_oe       <= route_c && tap_valid;
      c_o        <= (route_c && tap_valid) ? tap_data : '0;
      contention <= contention || cont_now;
      case (state)
        ST_OFF: begin
          if (en) begin
            dir_q <= dir;
            dly_q <= dly_eff;
            state <= fwd_of_dir;
          end
        end
        ST_FWD_AC, ST_FWD_CA: begin
          if (exit_req) begin
            state <= ST_DRAIN;
            busy  <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (!any_valid) begin
            state      <= ST_TURN;
            turn_cnt   <= CW'(TURN_GAP - 1);
            contention <= 1'b0;
          end
        end
        ST_TURN: begin
          if (turn_done) begin
            busy <= 1'b0;
            if (en) begin
              dir_q <= dir;
              dly_q <= dly_eff;
              state <= fwd_of_dir;
            end else begin
              state <= ST_OFF;
            end
          end else begin
            turn_cnt <= turn_cnt - CW'(1);
          end
        end
        default: begin
          state <= ST_OFF;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bidir_delay_switch.sv
// tb/tb_bidir_delay_switch.sv - self-checking bench for bidir_delay_switch

module tb_bidir_delay_switch;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       dir = 1'b0;
  logic [4:0] dly = '0;
  logic [7:0] a_drv = '0;
  logic [7:0] c_drv = '0;
  logic       a_bad = 1'b0;
  logic       c_bad = 1'b0;
  logic [7:0] a_i, a_o, c_i, c_o;
  logic       a_oe, c_oe, busy, contention;

  int checks = 0;
  int errors = 0;

  // Pad model: a driven pad reads back its own drive unless corrupted.
  assign a_i = a_oe ? (a_bad ? ~a_o : a_o) : a_drv;
  assign c_i = c_oe ? (c_bad ? ~c_o : c_o) : c_drv;

  bidir_delay_switch #(
    .WIDTH    (8),
    .MAX_DLY  (16),
    .TURN_GAP (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .dir        (dir),
    .dly        (dly),
    .a_i        (a_i),
    .a_o        (a_o),
    .a_oe       (a_oe),
    .c_i        (c_i),
    .c_o        (c_o),
    .c_oe       (c_oe),
    .busy       (busy),
    .contention (contention)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       dir;
    logic [4:0] dly;
    logic [7:0] data;
    int         exp_lat;
  } lat_vec_t;

  lat_vec_t vecs [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    dir   = 1'b0;
    dly   = '0;
    a_drv = '0;
    c_drv = '0;
    a_bad = 1'b0;
    c_bad = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int         lat;
    logic       other_hi;
    logic       early;
    logic [7:0] d;

    vecs[0] = '{dir: 1'b0, dly: 5'd3,  data: 8'h5A, exp_lat: 3};
    vecs[1] = '{dir: 1'b0, dly: 5'd0,  data: 8'hA5, exp_lat: 1};
    vecs[2] = '{dir: 1'b0, dly: 5'd21, data: 8'h3C, exp_lat: 16};
    vecs[3] = '{dir: 1'b1, dly: 5'd2,  data: 8'hC3, exp_lat: 2};
    vecs[4] = '{dir: 1'b1, dly: 5'd16, data: 8'h81, exp_lat: 16};
    vecs[5] = '{dir: 1'b0, dly: 5'd1,  data: 8'hFF, exp_lat: 1};
    vecs[6] = '{dir: 1'b1, dly: 5'd0,  data: 8'h11, exp_lat: 1};

    // Reset values
    do_reset();
    chk("reset a_o", 32'(a_o), 0);
    chk("reset a_oe", 32'(a_oe), 0);
    chk("reset c_o", 32'(c_o), 0);
    chk("reset c_oe", 32'(c_oe), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset contention", 32'(contention), 0);

    // Latency/clamp table: first sample at edge 0, second at edge 1
    for (int i = 0; i < 7; i++) begin
      do_reset();
      en  = 1'b1;
      dir = vecs[i].dir;
      dly = vecs[i].dly;
      d   = vecs[i].data;
      if (vecs[i].dir == 1'b0) a_drv = d; else c_drv = d;
      tick();
      if (vecs[i].dir == 1'b0) a_drv = 8'(d + 8'd1); else c_drv = 8'(d + 8'd1);
      lat      = 0;
      other_hi = 1'b0;
      for (int k = 1; k <= 40 && lat == 0; k++) begin
        tick();
        if (vecs[i].dir == 1'b0) begin
          if (a_oe) other_hi = 1'b1;
          if (c_oe) lat = k;
        end else begin
          if (c_oe) other_hi = 1'b1;
          if (a_oe) lat = k;
        end
      end
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      chk($sformatf("vec%0d first data", i), 32'(vecs[i].dir ? a_o : c_o), 32'(d));
      chk($sformatf("vec%0d other side oe", i), 32'(other_hi), 0);
      tick();
      chk($sformatf("vec%0d second data", i), 32'(vecs[i].dir ? a_o : c_o), 32'(8'(d + 8'd1)));
    end

    // Direction switch A->C to C->A with dly=4, new dly=2 set during drain
    do_reset();
    en = 1'b1; dir = 1'b0; dly = 5'd4; c_drv = 8'h77; a_drv = 8'h10;
    tick();
    for (int k = 1; k <= 20; k++) begin
      a_drv = 8'(8'h10 + k);
      tick();
    end
    dir = 1'b1;
    for (int k = 21; k <= 34; k++) begin
      if (k == 22) dly = 5'd2;
      a_drv = 8'(8'h10 + k);
      tick();
      chk($sformatf("switch c_oe e%0d", k), 32'(c_oe), 32'(k <= 24));
      chk($sformatf("switch a_oe e%0d", k), 32'(a_oe), 32'(k >= 29));
      chk($sformatf("switch busy e%0d", k), 32'(busy), 32'(k >= 21 && k <= 26));
      if (k == 24) chk("switch last drained c_o", 32'(c_o), 32'h24);
      if (k == 29) chk("switch first a_o", 32'(a_o), 32'h77);
    end

    // Contention on the C side, sticky, cleared on TURN
    do_reset();
    en = 1'b1; dir = 1'b0; dly = 5'd2; a_drv = 8'h33;
    tick();
    tick();
    tick();
    chk("cont c_oe up", 32'(c_oe), 1);
    tick();
    chk("cont before fault", 32'(contention), 0);
    c_bad = 1'b1;
    tick();
    chk("cont set", 32'(contention), 1);
    c_bad = 1'b0;
    tick();
    tick();
    chk("cont sticky", 32'(contention), 1);
    dir = 1'b1;
    tick();
    tick();
    chk("cont held in drain", 32'(contention), 1);
    tick();
    chk("cont cleared at turn", 32'(contention), 0);
    chk("cont c_oe low at turn", 32'(c_oe), 0);

    // Reset asserted mid-drain
    do_reset();
    en = 1'b1; dir = 1'b0; dly = 5'd8; a_drv = 8'h5C;
    tick();
    repeat (10) tick();
    en = 1'b0;
    tick();
    tick();
    chk("rst pre busy", 32'(busy), 1);
    chk("rst pre c_oe", 32'(c_oe), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst async c_oe", 32'(c_oe), 0);
    chk("rst async c_o", 32'(c_o), 0);
    chk("rst async busy", 32'(busy), 0);
    chk("rst async a_oe", 32'(a_oe), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("rst off c_oe", 32'(c_oe), 0);
    chk("rst off busy", 32'(busy), 0);
    en = 1'b1; dir = 1'b0;
    tick();
    early = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (c_oe) early = 1'b1;
    end
    chk("rst line empty", 32'(early), 0);
    tick();
    chk("rst refill c_oe", 32'(c_oe), 1);

    // en=0 in FWD_CA: drain on A, TURN, then OFF while dir toggles
    do_reset();
    en = 1'b1; dir = 1'b1; dly = 5'd3; c_drv = 8'h40;
    tick();
    for (int k = 1; k <= 10; k++) begin
      c_drv = 8'(8'h40 + k);
      tick();
    end
    en = 1'b0;
    for (int k = 11; k <= 24; k++) begin
      if (k >= 16) dir = ~dir;
      c_drv = 8'(8'h40 + k);
      tick();
      chk($sformatf("off a_oe e%0d", k), 32'(a_oe), 32'(k <= 13));
      chk($sformatf("off c_oe e%0d", k), 32'(c_oe), 0);
      chk($sformatf("off busy e%0d", k), 32'(busy), 32'(k >= 11 && k <= 15));
      if (k == 13) chk("off last a_o", 32'(a_o), 32'h4A);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
